lpc_io_dispatch: RTL



---
 rtl/lpc_io_dispatch_pkg.sv | 12 +
 rtl/lpc_win_decode.sv | 24 ++
 rtl/lpc_io_dispatch.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lpc_io_dispatch_pkg.sv
// Shared encodings for the LPC I/O dispatcher: FSM state codes and the float-bus value.
package lpc_io_dispatch_pkg;
  localparam int NUM_TGT = 4;

  localparam logic [2:0] LPC_DSP_ST_IDLE    = 3'd0;
  localparam logic [2:0] LPC_DSP_ST_RD_ACC  = 3'd1;
  localparam logic [2:0] LPC_DSP_ST_RD_HOLD = 3'd2;
  localparam logic [2:0] LPC_DSP_ST_WR_ACC  = 3'd3;
  localparam logic [2:0] LPC_DSP_ST_WR_HOLD = 3'd4;

  localparam logic [7:0] LPC_FLOAT_DATA = 8'hFF;
endpackage

// File: rtl/lpc_win_decode.sv
// Combinational priority base/mask window matcher; lowest-index matching window wins.
module lpc_win_decode
  import lpc_io_dispatch_pkg::*;
#(
  parameter logic [63:0] TGT_BASE = 64'h0000_0000_0080_0000,
  parameter logic [63:0] TGT_MASK = 64'h0000_0000_FFFF_FFFF
) (
  input  logic [15:0] addr,
  output logic [3:0]  sel,
  output logic        hit
);
  always_comb begin
    sel = '0;
    hit = 1'b0;
    // Walk from the highest index down so the lowest matching window is written last.
    for (int n = NUM_TGT - 1; n >= 0; n--) begin
      if ((addr & TGT_MASK[16*n +: 16]) == (TGT_BASE[16*n +: 16] & TGT_MASK[16*n +: 16])) begin
        sel    = '0;
        sel[n] = 1'b1;
        hit    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lpc_io_dispatch.sv
// LPC I/O transaction dispatcher: decodes host I/O cycles onto four select/ack targets.
// Optional target-ack timeout enabled by defining LPC_DISPATCH_TIMEOUT_EN.
module lpc_io_dispatch
  import lpc_io_dispatch_pkg::*;
#(
  parameter logic [63:0] TGT_BASE    = 64'h0000_0000_0080_0000,
  parameter logic [63:0] TGT_MASK    = 64'h0000_0000_FFFF_FFFF,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] lpc_addr_i,
  input  logic [7:0]  lpc_wdata_i,
  input  logic        lpc_data_wr_i,
  output logic        lpc_wr_done_o,
  input  logic        lpc_data_req_i,
  output logic        lpc_data_rd_o,
  output logic [7:0]  lpc_rdata_o,
  output logic [3:0]  tgt_sel_o,
  output logic        tgt_we_o,
  output logic [15:0] tgt_addr_o,
  output logic [7:0]  tgt_wdata_o,
  input  logic [31:0] tgt_rdata_i,
  input  logic [3:0]  tgt_ack_i,
  output logic        err_o
);
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

  logic [2:0] state;
  logic       req_q, wr_q;
  logic       wr_edge, rd_edge;
  logic [3:0] dec_sel;
  logic       dec_hit;
  logic       ack_sel;
  logic       expire;
  logic [7:0] rdata_sel;

  lpc_win_decode #(.TGT_BASE(TGT_BASE), .TGT_MASK(TGT_MASK)) u_dec (
    .addr (lpc_addr_i),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  assign wr_edge = lpc_data_wr_i & ~wr_q;
  assign rd_edge = lpc_data_req_i & ~req_q;
  assign ack_sel = |(tgt_ack_i & tgt_sel_o);

  always_comb begin
    rdata_sel = '0;
    for (int n = 0; n < NUM_TGT; n++) begin
      if (tgt_sel_o[n]) rdata_sel = rdata_sel | tgt_rdata_i[8*n +: 8];
    end
  end

`ifdef LPC_DISPATCH_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       err_q;

  assign expire = (to_cnt == 8'(TIMEOUT_CYC - 1));
  assign err_o  = err_q;

  // Counter idles at zero outside the ACC states, so it is already clear on entry.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      to_cnt <= '0;
    else if (state == LPC_DSP_ST_RD_ACC || state == LPC_DSP_ST_WR_ACC)
      to_cnt <= to_cnt + 8'd1;
    else
      to_cnt <= '0;
  end
`else
  assign expire = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    // Edge history tracks the inputs through reset so a level held across reset is not an edge.
    req_q <= lpc_data_req_i;
    wr_q  <= lpc_data_wr_i;
    if (rst_i) begin
      state         <= LPC_DSP_ST_IDLE;
      tgt_sel_o     <= '0;
      tgt_we_o      <= 1'b0;
      tgt_addr_o    <= '0;
      tgt_wdata_o   <= '0;
      lpc_rdata_o   <= LPC_FLOAT_DATA;
      lpc_data_rd_o <= 1'b0;
      lpc_wr_done_o <= 1'b0;
`ifdef LPC_DISPATCH_TIMEOUT_EN
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        LPC_DSP_ST_IDLE: begin
          if (wr_edge || rd_edge) begin
            tgt_addr_o  <= lpc_addr_i;
            tgt_wdata_o <= lpc_wdata_i;
            tgt_sel_o   <= dec_sel;
            tgt_we_o    <= wr_edge & dec_hit;
            if (dec_hit) begin
              state <= wr_edge ? LPC_DSP_ST_WR_ACC : LPC_DSP_ST_RD_ACC;
            end else if (wr_edge) begin
              state         <= LPC_DSP_ST_WR_HOLD;
              lpc_wr_done_o <= 1'b1;
            end else begin
              state         <= LPC_DSP_ST_RD_HOLD;
              lpc_rdata_o   <= LPC_FLOAT_DATA;
              lpc_data_rd_o <= 1'b1;
            end
          end
        end
        LPC_DSP_ST_RD_ACC, LPC_DSP_ST_WR_ACC: begin
          // A real ack on the expiry cycle takes precedence over the timeout.
          if (ack_sel || expire) begin
            tgt_sel_o <= '0;
            tgt_we_o  <= 1'b0;
            if (state == LPC_DSP_ST_RD_ACC) begin
              state         <= LPC_DSP_ST_RD_HOLD;
              lpc_rdata_o   <= ack_sel ? rdata_sel : LPC_FLOAT_DATA;
              lpc_data_rd_o <= 1'b1;
            end else begin
              state         <= LPC_DSP_ST_WR_HOLD;
              lpc_wr_done_o <= 1'b1;
            end
`ifdef LPC_DISPATCH_TIMEOUT_EN
            if (!ack_sel) err_q <= 1'b1;
`endif
          end
        end
        LPC_DSP_ST_RD_HOLD: begin
          if (!lpc_data_req_i) begin
            state         <= LPC_DSP_ST_IDLE;
            lpc_data_rd_o <= 1'b0;
          end
        end
        LPC_DSP_ST_WR_HOLD: begin
          if (!lpc_data_wr_i) begin
            state         <= LPC_DSP_ST_IDLE;
            lpc_wr_done_o <= 1'b0;
          end
        end
        default: state <= LPC_DSP_ST_IDLE;
      endcase
    end
  end
endmodule
